// File: rtl/hilo_unit_if.sv
// Operand/result bundle between the pipeline and the HI/LO unit.
// The master presents ops and operands; the slave returns HI/LO and divide status.
interface hilo_unit_if;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] alu_r;
    logic [31:0] alu_r2;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    modport master (
        output op_valid, op, alu_r, alu_r2, rs_val, rt_val,
        input  hi, lo, busy, done, div_by_zero
    );

    modport slave (
        input  op_valid, op, alu_r, alu_r2, rs_val, rt_val,
        output hi, lo, busy, done, div_by_zero
    );
endinterface

// File: rtl/hilo_unit.sv
// HI/LO register unit: MULTU capture, MTHI/MTLO, and a 32-step restoring divider
// for DIV/DIVU that stalls the pipeline through busy while it iterates.
module hilo_unit (
    input logic        clk,
    input logic        rst_n,
    hilo_unit_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StIter = 2'd1,
        StFix  = 2'd2
    } state_e;

    state_e      state;
    logic [5:0]  cnt;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] dvsr;
    logic        q_neg;
    logic        r_neg;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        busy_q;
    logic        done_q;
    logic        dbz_q;

    logic        accept;
    logic        is_signed;
    logic [31:0] rs_mag;
    logic [31:0] rt_mag;
    logic [32:0] rem_sh;
    logic [31:0] rem_nxt;
    logic [31:0] quo_nxt;

    always_comb begin
        accept    = bus.op_valid && !busy_q;
        is_signed = (bus.op == 3'd2);
        // Magnitudes are taken as 32-bit unsigned, so |0x80000000| stays 0x80000000.
        rs_mag    = (is_signed && bus.rs_val[31]) ? -bus.rs_val : bus.rs_val;
        rt_mag    = (is_signed && bus.rt_val[31]) ? -bus.rt_val : bus.rt_val;
        rem_sh    = {rem, quo[31]};
        rem_nxt   = rem_sh[31:0];
        quo_nxt   = {quo[30:0], 1'b0};
        if (rem_sh >= {1'b0, dvsr}) begin
            rem_nxt = rem_sh[31:0] - dvsr;
            quo_nxt = {quo[30:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= StIdle;
            cnt    <= 6'd0;
            rem    <= 32'd0;
            quo    <= 32'd0;
            dvsr   <= 32'd0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state)
                StIdle: begin
                    if (accept) begin
                        case (bus.op)
                            3'd1: begin
                                lo_q <= bus.alu_r;
                                hi_q <= bus.alu_r2;
                            end
                            3'd2, 3'd3: begin
                                if (bus.rt_val == 32'd0) begin
                                    lo_q   <= 32'hFFFF_FFFF;
                                    hi_q   <= bus.rs_val;
                                    done_q <= 1'b1;
                                    dbz_q  <= 1'b1;
                                end else begin
                                    dvsr   <= rt_mag;
                                    quo    <= rs_mag;
                                    rem    <= 32'd0;
                                    cnt    <= 6'd0;
                                    q_neg  <= is_signed && (bus.rs_val[31] ^ bus.rt_val[31]);
                                    r_neg  <= is_signed && bus.rs_val[31];
                                    busy_q <= 1'b1;
                                    state  <= StIter;
                                end
                            end
                            3'd4: hi_q <= bus.rs_val;
                            3'd5: lo_q <= bus.rs_val;
                            default: ;
                        endcase
                    end
                end
                StIter: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        state <= StFix;
                    end
                end
                StFix: begin
                    lo_q   <= q_neg ? -quo : quo;
                    hi_q   <= r_neg ? -rem : rem;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit: MULTU/MTHI/MTLO, signed and unsigned divides,
// zero divisor, ops while busy and an asynchronous reset mid-divide.
module tb_hilo_unit;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    hilo_unit_if bus ();

    hilo_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one op for exactly one rising edge; returns 1 time unit after that edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] r, input logic [31:0] r2);
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op       = op;
        bus.rs_val   = rs;
        bus.rt_val   = rt;
        bus.alu_r    = r;
        bus.alu_r2   = r2;
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        bus.op       = 3'd0;
    endtask

    // Step edges until busy drops (bounded); any held op is withdrawn as soon as it does.
    task automatic wait_idle(output int cycles, output int done_cnt);
        cycles   = 0;
        done_cnt = 0;
        while (bus.busy && cycles < 60) begin
            @(posedge clk);
            #1;
            cycles++;
            if (bus.done) done_cnt++;
            if (!bus.busy) begin
                bus.op_valid = 1'b0;
                bus.op       = 3'd0;
            end
        end
    endtask

    task automatic run_div(input string tag, input logic [2:0] op, input logic [31:0] rs,
                           input logic [31:0] rt, input logic [31:0] exp_lo,
                           input logic [31:0] exp_hi);
        int cycles;
        int done_cnt;
        issue(op, rs, rt, 32'd0, 32'd0);
        chk({tag, "_busy_start"}, {31'd0, bus.busy}, 32'd1);
        wait_idle(cycles, done_cnt);
        chk({tag, "_busy_cycles"}, cycles, 32'd33);
        chk({tag, "_done_pulses"}, done_cnt, 32'd1);
        chk({tag, "_dbz"}, {31'd0, bus.div_by_zero}, 32'd0);
        chk({tag, "_lo"}, bus.lo, exp_lo);
        chk({tag, "_hi"}, bus.hi, exp_hi);
        @(posedge clk);
        #1;
        chk({tag, "_done_clear"}, {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        int cycles;
        int done_cnt;
        int seen;

        n_cmp        = 0;
        n_err        = 0;
        rst_n        = 1'b0;
        bus.op_valid = 1'b0;
        bus.op       = 3'd0;
        bus.alu_r    = 32'd0;
        bus.alu_r2   = 32'd0;
        bus.rs_val   = 32'd0;
        bus.rt_val   = 32'd0;

        repeat (2) @(negedge clk);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_dbz", {31'd0, bus.div_by_zero}, 32'd0);
        rst_n = 1'b1;

        issue(3'd1, 32'd0, 32'd0, 32'h89AB_CDEF, 32'h0123_4567);
        chk("multu_hi", bus.hi, 32'h0123_4567);
        chk("multu_lo", bus.lo, 32'h89AB_CDEF);
        chk("multu_busy", {31'd0, bus.busy}, 32'd0);

        issue(3'd4, 32'hAAAA_5555, 32'd0, 32'd0, 32'd0);
        chk("mthi_hi", bus.hi, 32'hAAAA_5555);
        chk("mthi_lo_kept", bus.lo, 32'h89AB_CDEF);
        issue(3'd5, 32'h1357_9BDF, 32'd0, 32'd0, 32'd0);
        chk("mtlo_lo", bus.lo, 32'h1357_9BDF);
        chk("mtlo_hi_kept", bus.hi, 32'hAAAA_5555);

        issue(3'd6, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("nop_hi", bus.hi, 32'hAAAA_5555);
        chk("nop_busy", {31'd0, bus.busy}, 32'd0);

        run_div("divu_100_7", 3'd3, 32'd100, 32'd7, 32'd14, 32'd2);
        run_div("divu_max_16", 3'd3, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF);
        run_div("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_div("div_7_m2", 3'd2, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        run_div("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        run_div("divu_big", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

        issue(3'd3, 32'd5, 32'd0, 32'd0, 32'd0);
        chk("dbz_lo", bus.lo, 32'hFFFF_FFFF);
        chk("dbz_hi", bus.hi, 32'd5);
        chk("dbz_done", {31'd0, bus.done}, 32'd1);
        chk("dbz_flag", {31'd0, bus.div_by_zero}, 32'd1);
        chk("dbz_busy", {31'd0, bus.busy}, 32'd0);
        @(posedge clk);
        #1;
        chk("dbz_done_clear", {31'd0, bus.done}, 32'd0);
        chk("dbz_flag_clear", {31'd0, bus.div_by_zero}, 32'd0);
        chk("dbz_busy_after", {31'd0, bus.busy}, 32'd0);

        // MTHI held valid for the whole divide, including the final busy cycle.
        issue(3'd3, 32'd100, 32'd7, 32'd0, 32'd0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        bus.op_valid = 1'b1;
        bus.op       = 3'd4;
        bus.rs_val   = 32'h0000_DEAD;
        @(posedge clk);
        #1;
        chk("busy_mthi_hold_hi", bus.hi, 32'd5);
        chk("busy_mthi_hold_lo", bus.lo, 32'hFFFF_FFFF);
        wait_idle(cycles, done_cnt);
        chk("busy_mthi_cycles", cycles + 5, 32'd33);
        chk("busy_mthi_done", done_cnt, 32'd1);
        chk("busy_mthi_hi", bus.hi, 32'd2);
        chk("busy_mthi_lo", bus.lo, 32'd14);
        @(posedge clk);
        #1;
        chk("busy_mthi_hi_after", bus.hi, 32'd2);

        issue(3'd3, 32'd100, 32'd7, 32'd0, 32'd0);
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rstmid_hi", bus.hi, 32'd0);
        chk("rstmid_lo", bus.lo, 32'd0);
        chk("rstmid_busy", {31'd0, bus.busy}, 32'd0);
        chk("rstmid_done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) seen++;
        end
        chk("rstmid_no_done", seen, 32'd0);
        issue(3'd5, 32'h0000_1234, 32'd0, 32'd0, 32'd0);
        chk("rstmid_mtlo_lo", bus.lo, 32'h0000_1234);
        chk("rstmid_mtlo_hi", bus.hi, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
